run_monitor: RTL

//  Synthesizable end-of-run checker sitting directly downstream of cpu. It counts

---
 rtl/run_monitor.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/run_monitor.sv
// run_monitor: end-of-run checker downstream of the cpu. Counts cycles until halt or
// timeout, snapshots pc/x28 and the verdict from x31, then streams a 14-byte result
// record over a valid/ready byte port and parks in DONE until reset.
module run_monitor #(
   parameter int unsigned TIMEOUT   = 1000,
   parameter logic [31:0] PASS_CODE = 32'h55,
   parameter logic [31:0] FAIL_CODE = 32'haa
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        halt,
   input  logic [31:0] pc,
   input  logic [31:0] x28,
   input  logic [31:0] x31,
   output logic        cpu_hold,
   output logic        done,
   output logic [1:0]  status,
   output logic        timed_out,
   output logic [31:0] cycle_count,
   output logic        rec_valid,
   output logic [7:0]  rec_data,
   input  logic        rec_ready
);

   typedef enum logic [1:0] {StRun, StSend, StDone} state_e;

   localparam logic [3:0] LastIdx = 4'd13;

   state_e      state_q, state_d;
   logic [31:0] cycle_q, cycle_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] x28_q, x28_d;
   logic [1:0]  status_q, status_d;
   logic        timed_out_q, timed_out_d;
   logic        hold_q, hold_d;
   logic        valid_q, valid_d;
   logic        done_q, done_d;
   logic [3:0]  idx_q, idx_d;
   logic [1:0]  verdict;
   logic [7:0]  byte_sel;

   // Verdict decoded from the result register; anything unexpected is an error
   always_comb begin
      if (x31 == PASS_CODE) begin
         verdict = 2'b01;
      end else if (x31 == FAIL_CODE) begin
         verdict = 2'b10;
      end else begin
         verdict = 2'b11;
      end
   end

   // State register and all snapshot/status flops
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StRun;
         cycle_q     <= '0;
         pc_q        <= '0;
         x28_q       <= '0;
         status_q    <= '0;
         timed_out_q <= 1'b0;
         hold_q      <= 1'b0;
         valid_q     <= 1'b0;
         done_q      <= 1'b0;
         idx_q       <= '0;
      end else begin
         state_q     <= state_d;
         cycle_q     <= cycle_d;
         pc_q        <= pc_d;
         x28_q       <= x28_d;
         status_q    <= status_d;
         timed_out_q <= timed_out_d;
         hold_q      <= hold_d;
         valid_q     <= valid_d;
         done_q      <= done_d;
         idx_q       <= idx_d;
      end
   end

   // Next-state: count in RUN, capture on halt/timeout, step the byte index in SEND
   always_comb begin
      state_d     = state_q;
      cycle_d     = cycle_q;
      pc_d        = pc_q;
      x28_d       = x28_q;
      status_d    = status_q;
      timed_out_d = timed_out_q;
      hold_d      = hold_q;
      valid_d     = valid_q;
      done_d      = done_q;
      idx_d       = idx_q;
      unique case (state_q)
         StRun: begin
            // halt takes priority over timeout on the same edge
            if (halt || (cycle_q == TIMEOUT)) begin
               pc_d        = pc;
               x28_d       = x28;
               status_d    = verdict;
               timed_out_d = ~halt;
               hold_d      = 1'b1;
               valid_d     = 1'b1;
               idx_d       = '0;
               state_d     = StSend;
            end else begin
               cycle_d = cycle_q + 32'd1;
            end
         end
         StSend: begin
            if (rec_ready) begin
               if (idx_q == LastIdx) begin
                  valid_d = 1'b0;
                  done_d  = 1'b1;
                  state_d = StDone;
               end else begin
                  idx_d = idx_q + 4'd1;
               end
            end
         end
         StDone: begin
         end
         default: state_d = StRun;
      endcase
   end

   // Record byte mux; forced to zero whenever no byte is offered
   always_comb begin
      byte_sel = 8'h00;
      unique case (idx_q)
         4'd0:    byte_sel = 8'hA5;
         4'd1:    byte_sel = {5'b0, timed_out_q, status_q};
         4'd2:    byte_sel = cycle_q[7:0];
         4'd3:    byte_sel = cycle_q[15:8];
         4'd4:    byte_sel = cycle_q[23:16];
         4'd5:    byte_sel = cycle_q[31:24];
         4'd6:    byte_sel = pc_q[7:0];
         4'd7:    byte_sel = pc_q[15:8];
         4'd8:    byte_sel = pc_q[23:16];
         4'd9:    byte_sel = pc_q[31:24];
         4'd10:   byte_sel = x28_q[7:0];
         4'd11:   byte_sel = x28_q[15:8];
         4'd12:   byte_sel = x28_q[23:16];
         4'd13:   byte_sel = x28_q[31:24];
         default: byte_sel = 8'h00;
      endcase
      rec_data = valid_q ? byte_sel : 8'h00;
   end

   assign cpu_hold    = hold_q;
   assign done        = done_q;
   assign status      = status_q;
   assign timed_out   = timed_out_q;
   assign cycle_count = cycle_q;
   assign rec_valid   = valid_q;

endmodule
